// File: rtl/hack_mem_responder.sv
// Hack CPU data-memory responder: RAM, buffered screen writes toward a
// valid/ready display sink, synchronized keyboard and a FIFO status word.
module hack_mem_responder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RAM_WORDS  = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  output logic        disp_valid,
  output logic [12:0] disp_addr,
  output logic [15:0] disp_data,
  input  logic        disp_ready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [15:0]   ram    [RAM_WORDS];
  logic [12:0]   f_addr [FIFO_DEPTH];
  logic [15:0]   f_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   kbd_s1, kbd_q;

  logic ram_hit, sel_scr, sel_kbd, sel_stat;
  logic empty, full, pop, scr_wr, push;
  logic [15:0] status;

  // RAM occupies the lower half; words past RAM_WORDS read as 0
  assign ram_hit  = (addressM[14] == 1'b0) && ({1'b0, addressM[13:0]} < 15'(RAM_WORDS));
  assign sel_scr  = (addressM[14:13] == 2'b10);
  assign sel_kbd  = (addressM == 15'h6000);
  assign sel_stat = (addressM == 15'h6001);

  assign empty  = (count == '0);
  assign full   = (count == CW'(FIFO_DEPTH));
  assign pop    = !empty && disp_ready;
  assign scr_wr = writeM && sel_scr;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign push   = scr_wr && (!full || pop);

  assign status = {overflow, 8'b0, 5'(count), full, empty};

  always_ff @(posedge clk) begin
    if (writeM && ram_hit) ram[addressM[RW-1:0]] <= outM;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wr_ptr] <= addressM[12:0];
      f_data[wr_ptr] <= outM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (scr_wr && !push)          overflow <= 1'b1;
      else if (writeM && sel_stat)  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbd_s1 <= '0;
      kbd_q  <= '0;
    end else begin
      kbd_s1 <= kbd_code;
      kbd_q  <= kbd_s1;
    end
  end

  always_comb begin
    inM = '0;
    if (ram_hit)       inM = ram[addressM[RW-1:0]];
    else if (sel_kbd)  inM = kbd_q;
    else if (sel_stat) inM = status;
  end

  // FIFO storage is not reset, so the head is masked while empty
  assign disp_valid = !empty;
  assign disp_addr  = empty ? '0 : f_addr[rd_ptr];
  assign disp_data  = empty ? '0 : f_data[rd_ptr];

endmodule

// File: tb/tb_hack_mem_responder.sv
// Bench for hack_mem_responder: directed scenarios plus random traffic,
// all checked against a queue-based memory-map model.
module tb_hack_mem_responder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WORDS = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] addressM = '0;
  logic [15:0] outM = '0;
  logic        writeM = 1'b0;
  logic [15:0] inM;
  logic [15:0] kbd_code = '0;
  logic        disp_valid;
  logic [12:0] disp_addr;
  logic [15:0] disp_data;
  logic        disp_ready = 1'b0;

  hack_mem_responder #(.FIFO_DEPTH(DEPTH), .RAM_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM), .kbd_code(kbd_code), .disp_valid(disp_valid), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_ready(disp_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [12:0] a; logic [15:0] d; } ent_t;
  ent_t        m_q[$];
  logic [15:0] m_ram[int];
  logic        m_ovf = 1'b0;
  logic [15:0] m_s1 = '0, m_kq = '0;

  int total = 0;
  int bad   = 0;

  logic [14:0] pool [8] = '{15'h0010, 15'h3FFF, 15'h0000, 15'h0001,
                            15'h0100, 15'h1ABC, 15'h2000, 15'h3FFE};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_status();
    int n = m_q.size();
    logic [15:0] s = '0;
    s[0]   = (n == 0);
    s[1]   = (n == int'(DEPTH));
    s[6:2] = 5'(n);
    s[15]  = m_ovf;
    return s;
  endfunction

  function automatic logic [15:0] m_read(input int a, output bit known);
    known = 1'b1;
    if (a < 'h4000) begin
      if (a >= int'(WORDS)) return '0;
      if (m_ram.exists(a)) return m_ram[a];
      known = 1'b0;
      return '0;
    end
    if (a == 'h6000) return m_kq;
    if (a == 'h6001) return m_status();
    return '0;
  endfunction

  // Applies one rising edge to the model using the currently driven inputs
  task automatic model_edge();
    int  a   = int'(addressM);
    bit  pop = (m_q.size() != 0) && disp_ready;
    bit  scr = writeM && (a >= 'h4000) && (a < 'h6000);
    bit  psh = scr && ((m_q.size() < int'(DEPTH)) || pop);
    ent_t e;
    if (pop) void'(m_q.pop_front());
    if (psh) begin
      e.a = 13'(a - 'h4000);
      e.d = outM;
      m_q.push_back(e);
    end
    if (scr && !psh) m_ovf = 1'b1;
    else if (writeM && a == 'h6001) m_ovf = 1'b0;
    if (writeM && a < int'(WORDS)) m_ram[a] = outM;
    m_kq = m_s1;
    m_s1 = kbd_code;
  endtask

  task automatic compare_outputs();
    bit known;
    logic [15:0] e = m_read(int'(addressM), known);
    if (known) check("inM", 32'(inM), 32'(e));
    check("disp_valid", 32'(disp_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("disp_addr", 32'(disp_addr), 32'(m_q[0].a));
      check("disp_data", 32'(disp_data), 32'(m_q[0].d));
    end
  endtask

  // Called at posedge+1; checks mid-cycle, then takes one edge
  task automatic step(input logic [14:0] a, input logic w, input logic [15:0] d, input logic rdy);
    addressM = a; writeM = w; outM = d; disp_ready = rdy;
    #3;
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic peek(input logic [14:0] a, input string tag, input logic [15:0] exp);
    addressM = a; writeM = 1'b0;
    #1;
    check(tag, 32'(inM), 32'(exp));
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) step(15'h6001, 1'b0, '0, 1'b1);
    check("drained", 32'(disp_valid), 32'd0);
  endtask

  initial begin
    #12;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_valid", 32'(disp_valid), 32'd0);
    check("rst_daddr", 32'(disp_addr), 32'd0);
    check("rst_ddata", 32'(disp_data), 32'd0);
    peek(15'h6001, "rst_status", 16'h0001);
    peek(15'h6000, "rst_kbd", 16'h0000);

    // RAM
    step(15'h0010, 1'b1, 16'h1234, 1'b0);
    peek(15'h0010, "ram_0010", 16'h1234);
    step(15'h3FFF, 1'b1, 16'hBEEF, 1'b0);
    peek(15'h3FFF, "ram_3fff", 16'hBEEF);
    peek(15'h6005, "unmapped", 16'h0000);
    step(15'h0010, 1'b0, '0, 1'b0);

    // keyboard
    kbd_code = 16'h0041;
    step(15'h6000, 1'b0, '0, 1'b0);
    peek(15'h6000, "kbd_c1", 16'h0000);
    step(15'h6000, 1'b0, '0, 1'b0);
    peek(15'h6000, "kbd_c2", 16'h0041);
    step(15'h6000, 1'b1, 16'h1111, 1'b0);
    peek(15'h6000, "kbd_wr", 16'h0041);

    // FIFO stall then drain
    step(15'h4000, 1'b1, 16'h00FF, 1'b0);
    step(15'h4001, 1'b1, 16'hAAAA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(15'h6001, 1'b0, '0, 1'b0);
      check("hold_addr", 32'(disp_addr), 32'h0000);
      check("hold_data", 32'(disp_data), 32'h00FF);
    end
    peek(15'h6001, "stall_status", 16'h0008);
    step(15'h6001, 1'b0, '0, 1'b1);
    step(15'h6001, 1'b0, '0, 1'b1);
    check("drain_valid", 32'(disp_valid), 32'd0);
    peek(15'h6001, "drain_status", 16'h0001);

    // overflow
    for (int i = 0; i < int'(DEPTH) + 2; i++)
      step(15'(15'h4000 + i), 1'b1, 16'(16'hC000 + i), 1'b0);
    peek(15'h6001, "ovf_status", 16'h8022);
    step(15'h6001, 1'b1, 16'hFFFF, 1'b0);
    peek(15'h6001, "ovf_clear", 16'h0022);

    // full with simultaneous pop
    step(15'h4010, 1'b1, 16'h5A5A, 1'b1);
    peek(15'h6001, "full_pop", 16'h0022);
    drain();

    // overflow set beats a same-cycle STATUS write is not reachable in one
    // address; instead check set while full at the address boundary
    for (int i = 0; i < int'(DEPTH); i++) step(15'h5FFF, 1'b1, 16'(i), 1'b0);
    step(15'h5FFF, 1'b1, 16'hDEAD, 1'b0);
    peek(15'h6001, "ovf_5fff", 16'h8022);
    drain();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      int unsigned r = $urandom_range(0, 99);
      logic [14:0] a;
      logic w = 1'($urandom_range(0, 1));
      if (r < 30)      a = pool[$urandom_range(0, 7)];
      else if (r < 65) a = 15'(15'h4000 + $urandom_range(0, 15'h1FFF));
      else if (r < 75) a = 15'h6000;
      else if (r < 85) begin a = 15'h6001; w = ($urandom_range(0, 5) == 0); end
      else             a = 15'(15'h6002 + $urandom_range(0, 15'h1FFD));
      if ($urandom_range(0, 9) == 0) kbd_code = 16'($urandom);
      step(a, w, 16'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    // asynchronous reset with three entries queued
    drain();
    for (int i = 0; i < 3; i++) step(15'(15'h4100 + i), 1'b1, 16'(16'h7000 + i), 1'b0);
    check("pre_rst_valid", 32'(disp_valid), 32'd1);
    writeM = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 32'(disp_valid), 32'd0);
    peek(15'h6001, "arst_status", 16'h0001);
    m_q.delete();
    m_ovf = 1'b0;
    m_s1 = '0;
    m_kq = '0;
    #1 rst = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    peek(15'h0010, "post_rst_ram", m_ram[32'h0010]);
    peek(15'h3FFF, "post_rst_ram2", m_ram[32'h3FFF]);
    for (int i = 0; i < 8; i++) step(pool[i], 1'b0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hack_mem_responder.md
# hack_mem_responder

Data-memory responder for the Hack CPU's memory port. Services every `addressM`/`writeM`/`outM` access and returns `inM`. Maps general RAM, a screen write path, a keyboard register and a status register into the 15-bit data address space. Screen writes are buffered in a FIFO and drained to an external display sink over a valid/ready handshake, so the CPU never stalls.

## Interface
- `FIFO_DEPTH`, 8: screen write FIFO depth; power of two, 2..16.
- `RAM_WORDS`, 16384: general RAM words implemented at 0x0000 upward; ≤16384.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `addressM`  in  15  CPU data address.
- `outM`  in  16  CPU write data.
- `writeM`  in  1  CPU write enable for the current cycle.
- `inM`  out  16  read data for `addressM`; combinational.
- `kbd_code`  in  16  raw keyboard scan code, asynchronous to the CPU; 0 = no key.
- `disp_valid`  out  1  FIFO head entry is presented.
- `disp_addr`  out  13  screen word offset (`addressM - 0x4000`).
- `disp_data`  out  16  screen pixel word.
- `disp_ready`  in  1  display sink accepts the head entry.

## Operation
- **Address decode** on `addressM`:
  - **0x0000–0x3FFF, RAM:** read is asynchronous. Write when `writeM` is high, at the rising edge. Addresses ≥ `RAM_WORDS` inside this range read 0 and ignore writes.
  - **0x4000–0x5FFF, SCREEN:** reads return 0. A write pushes {`addressM[12:0]`, `outM`} into the FIFO.
  - **0x6000, KBD:** read returns `kbd_q`. Writes are ignored.
  - **0x6001, STATUS:**
    - Read layout: bit0 = empty, bit1 = full, bits[6:2] = occupancy count, bits[14:7] = 0, bit15 = overflow sticky.
    - Any write clears the overflow sticky.
  - **0x6002–0x7FFF:** reads return 0 and writes are ignored.
- **Keyboard path:** two-flop synchronizer. `kbd_s1 <= kbd_code`, then `kbd_q <= kbd_s1`.
- **FIFO:**
  - Circular buffer with read and write pointers of width log2(`FIFO_DEPTH`).
  - `count` has width log2(`FIFO_DEPTH`)+1.
  - Head is shown on `disp_addr`/`disp_data` with `disp_valid = (count != 0)`.
  - Pop when `disp_valid && disp_ready`.
  - Push when a SCREEN write occurs and either `count < FIFO_DEPTH` or a pop happens in the same cycle.
- **Full-FIFO behaviour:**
  - A screen write arriving while full with no same-cycle pop is dropped and sets overflow at that edge.
  - Overflow set and a STATUS write in the same cycle: set wins.
- **Count update:** `count` increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- **Pointer wrap:** pointers wrap modulo `FIFO_DEPTH`.
- **Display handshake rules:**
  - `disp_addr`/`disp_data` hold stable while `disp_valid && !disp_ready`.
  - `disp_valid` never drops without a pop.
- **Reset:**
  - Reset values: `count`=0, both pointers=0, overflow=0, `kbd_s1`=`kbd_q`=0.
  - Resulting outputs: `disp_valid`=0, `disp_addr`=0, `disp_data`=0, `inM` follows decode (STATUS reads 0x0001).
  - RAM contents are not cleared.
  - Asserting reset mid-operation discards all FIFO entries immediately, without waiting for a clock edge.

## Timing
- **`inM`:** combinational from `addressM` plus current state, with zero-cycle latency. The CPU samples `inM` in the same cycle it issues `addressM`.
- **Write visibility:** a RAM write at edge N is visible to reads from cycle N+1.
- **Screen write latency:** a SCREEN write at edge N gives `disp_valid`=1 in cycle N+1 if the FIFO was empty. Minimum write-to-display latency is one cycle. There is no bypass path.
- **Keyboard latency:** a `kbd_code` change appears at KBD reads two rising edges later.
- **STATUS timing:** STATUS reflects state after the most recent edge. A push at edge N shows in `count` from cycle N+1.
- **Throughput:** the sustained FIFO rate is one push and one pop per cycle.

## Test plan
- **RAM:** write 0x1234 to 0x0010, write 0xBEEF to 0x3FFF, then read both. Required: `inM` = 0x1234 and 0xBEEF in the cycle after each write. Reading 0x6005 returns 0.
- **FIFO drain and stall:**
  - With `disp_ready`=0, write 0x00FF to 0x4000 and 0xAAAA to 0x4001. Required: `disp_valid`=1, head = {0x0000, 0x00FF} held stable, STATUS = 0x0008.
  - Raise `disp_ready`. Required: entries pop in order over 2 cycles, then `disp_valid`=0 and STATUS = 0x0001.
- **Overflow:**
  - With `disp_ready`=0, perform `FIFO_DEPTH`+2 screen writes. Required: count=8, STATUS = 0x8022, and the two extra entries are absent when drained.
  - Write STATUS. Required: bit15 clears.
- **Full + simultaneous pop:** with the FIFO full and `disp_ready`=1, write to 0x4010. Required: the write is accepted, count stays 8, overflow stays 0, and the new entry drains last.
- **Keyboard:** set `kbd_code`=0x0041 at cycle 0. Required: KBD reads 0 at cycle 1 and 0x0041 from cycle 2. A write of 0x1111 to 0x6000 leaves KBD unchanged.
- **Reset mid-operation:** assert `rst` asynchronously between edges with 3 entries queued. Required: `disp_valid` goes to 0 without a clock edge and STATUS = 0x0001. Previously written RAM words still read back after `rst` deasserts.
